// File: rtl/ser_pkg.sv
// Shared types and helpers for the serial front end of the "101" detector.
package ser_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    localparam int DEFAULT_DATA_W = 8;
    localparam int MAX_W          = 64;
    localparam int SEL_W          = $clog2(MAX_W);

    // idx is the emission ordinal (0 = first bit on the line), not a bit position.
    function automatic logic bit_sel(
        input logic [MAX_W-1:0] word,
        input int unsigned      idx,
        input int unsigned      width,
        input logic             msb_first
    );
        logic [SEL_W-1:0] pos;
        if (msb_first) begin
            pos = SEL_W'(width - 32'd1 - idx);
        end else begin
            pos = SEL_W'(idx);
        end
        return word[pos];
    endfunction

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: one holding buffer feeding a counted shifter,
// gapless across back-to-back words, idle level when nothing is pending.
module bit_serializer
    import ser_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              bit_en,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              frame_start,
    output logic              busy
);

    localparam int            RW       = $clog2(DATA_W);
    localparam logic [RW-1:0] LAST_CNT = RW'(DATA_W - 1);

    ser_state_t        state_r, state_s;
    logic [DATA_W-1:0] buf_word_r, buf_word_s;
    logic [DATA_W-1:0] sh_word_r, sh_word_s;
    logic              buf_full_r, buf_full_s;
    logic [RW-1:0]     remaining_r, remaining_s;
    logic              ser_out_s, ser_valid_s, frame_start_s;
    logic              accept_s;
    logic [MAX_W-1:0]  buf_ext_s, sh_ext_s;
    int unsigned       next_idx_s;

    assign in_ready = !buf_full_r;
    assign busy     = buf_full_r || (remaining_r != {RW{1'b0}});

    // Next-state logic for buffer, shifter, counter and serial outputs.
    always_comb begin
        state_s       = state_r;
        buf_word_s    = buf_word_r;
        buf_full_s    = buf_full_r;
        sh_word_s     = sh_word_r;
        remaining_s   = remaining_r;
        ser_out_s     = ser_out;
        ser_valid_s   = 1'b0;
        frame_start_s = 1'b0;
        buf_ext_s     = {MAX_W{1'b0}};
        sh_ext_s      = {MAX_W{1'b0}};
        buf_ext_s[DATA_W-1:0] = buf_word_r;
        sh_ext_s[DATA_W-1:0]  = sh_word_r;
        // The word stays put in sh_word; the counter picks the ordinal to emit.
        next_idx_s    = 32'(DATA_W) - 32'(remaining_r);
        accept_s      = in_valid && !buf_full_r;

        if (accept_s) begin
            buf_word_s = in_data;
            buf_full_s = 1'b1;
        end else begin
            buf_word_s = buf_word_r;
        end

        if (bit_en) begin
            if (remaining_r != {RW{1'b0}}) begin
                ser_out_s   = bit_sel(sh_ext_s, next_idx_s, 32'(DATA_W), MSB_FIRST);
                ser_valid_s = 1'b1;
                remaining_s = remaining_r - {{(RW-1){1'b0}}, 1'b1};
                state_s     = SHIFT;
            end else if (buf_full_r) begin
                // Load can never coincide with accept: they need opposite buf_full.
                sh_word_s     = buf_word_r;
                ser_out_s     = bit_sel(buf_ext_s, 32'd0, 32'(DATA_W), MSB_FIRST);
                ser_valid_s   = 1'b1;
                frame_start_s = 1'b1;
                remaining_s   = LAST_CNT;
                buf_full_s    = 1'b0;
                state_s       = SHIFT;
            end else begin
                ser_out_s = IDLE_BIT;
                state_s   = IDLE;
            end
        end else begin
            state_s = state_r;
        end
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            buf_word_r  <= {DATA_W{1'b0}};
            buf_full_r  <= 1'b0;
            sh_word_r   <= {DATA_W{1'b0}};
            remaining_r <= {RW{1'b0}};
            ser_out     <= IDLE_BIT;
            ser_valid   <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            state_r     <= state_s;
            buf_word_r  <= buf_word_s;
            buf_full_r  <= buf_full_s;
            sh_word_r   <= sh_word_s;
            remaining_r <= remaining_s;
            ser_out     <= ser_out_s;
            ser_valid   <= ser_valid_s;
            frame_start <= frame_start_s;
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: MSB-first and LSB-first instances share stimulus and
// are compared every cycle against a queue-of-bits reference.
module tb_bit_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] in_data = 8'h00;
    logic         in_valid = 1'b0;
    logic         bit_en = 1'b1;
    logic [1:0]   in_ready_v, ser_out_v, ser_valid_v, frame_start_v, busy_v;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: buffered word plus a queue of bits still to appear on the line.
    logic [W-1:0] m_buf;
    bit           m_full;
    bit           mq[$];
    bit           lq[$];
    logic [1:0]   m_out;
    bit           m_valid, m_fs, m_acc;
    int           n_acc = 0;

    bit_serializer #(.DATA_W(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_v[0]), .bit_en(bit_en), .ser_out(ser_out_v[0]),
        .ser_valid(ser_valid_v[0]), .frame_start(frame_start_v[0]), .busy(busy_v[0])
    );

    bit_serializer #(.DATA_W(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_v[1]), .bit_en(bit_en), .ser_out(ser_out_v[1]),
        .ser_valid(ser_valid_v[1]), .frame_start(frame_start_v[1]), .busy(busy_v[1])
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        lq.delete();
        m_full  = 1'b0;
        m_out   = 2'b00;
        m_valid = 1'b0;
        m_fs    = 1'b0;
        m_acc   = 1'b0;
    endtask

    task automatic model_step();
        m_acc   = in_valid && !m_full;
        m_valid = 1'b0;
        m_fs    = 1'b0;
        if (bit_en) begin
            if (mq.size() == 0 && m_full) begin
                for (int i = 0; i < W; i++) begin
                    mq.push_back(m_buf[W-1-i]);
                    lq.push_back(m_buf[i]);
                end
                m_full = 1'b0;
                m_fs   = 1'b1;
            end
            if (mq.size() > 0) begin
                m_out[0] = mq.pop_front();
                m_out[1] = lq.pop_front();
                m_valid  = 1'b1;
            end else begin
                m_out = 2'b00;
            end
        end
        if (m_acc) begin
            m_buf  = in_data;
            m_full = 1'b1;
            n_acc++;
        end
    endtask

    task automatic compare_all();
        logic busy_exp;
        busy_exp = m_full || (mq.size() != 0);
        chk("ser_out_msb",     32'(ser_out_v[0]),     32'(m_out[0]));
        chk("ser_out_lsb",     32'(ser_out_v[1]),     32'(m_out[1]));
        chk("ser_valid",       32'(ser_valid_v),      32'({2{m_valid}}));
        chk("frame_start",     32'(frame_start_v),    32'({2{m_fs}}));
        chk("in_ready",        32'(in_ready_v),       32'({2{!m_full}}));
        chk("busy",            32'(busy_v),           32'({2{busy_exp}}));
    endtask

    // One clock: model advances on the edge, outputs checked on the falling edge.
    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic send_collect(input logic [W-1:0] w, output logic [W-1:0] sm,
                                output logic [W-1:0] sl, output int vcnt,
                                output logic [W-1:0] fsb);
        sm = 8'h00; sl = 8'h00; fsb = 8'h00; vcnt = 0;
        bit_en = 1'b1; in_data = w; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < W; i++) begin
            step();
            sm = {sm[W-2:0], ser_out_v[0]};
            sl = {sl[W-2:0], ser_out_v[1]};
            vcnt += int'(ser_valid_v[0]);
            if (frame_start_v[0]) fsb[i] = 1'b1;
        end
    endtask

    logic [W-1:0] sm, sl, fsb, seq;
    int           vcnt, acc0, idx;
    int           acc_at[3];
    logic [W-1:0] words[3];
    logic [25:0]  rdy_got, v_got, f_got, rdy_exp, v_exp, f_exp;

    initial begin
        model_reset();
        @(negedge clk);
        chk("rst_ser_out",   32'(ser_out_v),   32'd0);
        chk("rst_ser_valid", 32'(ser_valid_v), 32'd0);
        chk("rst_in_ready",  32'(in_ready_v),  32'd3);
        chk("rst_busy",      32'(busy_v),      32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Single words, both bit orders.
        send_collect(8'hA5, sm, sl, vcnt, fsb);
        chk("a5_msb_seq", 32'(sm), 32'h0000_00A5);
        chk("a5_lsb_seq", 32'(sl), 32'h0000_00A5);
        chk("a5_vcnt",    32'(vcnt), 32'd8);
        chk("a5_fs",      32'(fsb), 32'h0000_0001);
        step();
        chk("a5_idle_valid", 32'(ser_valid_v), 32'd0);
        chk("a5_idle_out",   32'(ser_out_v),   32'd0);
        chk("a5_idle_busy",  32'(busy_v),      32'd0);
        send_collect(8'h01, sm, sl, vcnt, fsb);
        chk("01_msb_seq", 32'(sm), 32'h0000_0001);
        chk("01_lsb_seq", 32'(sl), 32'h0000_0080);
        repeat (2) step();

        // Back-to-back words with in_valid held.
        words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF;
        idx = 0; bit_en = 1'b1;
        for (int c = 0; c < 26; c++) begin
            in_valid = (idx < 3);
            in_data  = (idx < 3) ? words[idx] : 8'h00;
            step();
            if (m_acc) begin
                acc_at[idx] = c;
                idx++;
            end
            rdy_got[c] = in_ready_v[0];
            v_got[c]   = ser_valid_v[0];
            f_got[c]   = frame_start_v[0];
            rdy_exp[c] = (c == 1) || (c == 9) || (c >= 17);
            v_exp[c]   = (c >= 1) && (c <= 24);
            f_exp[c]   = (c == 1) || (c == 9) || (c == 17);
        end
        in_valid = 1'b0;
        chk("b2b_acc0", 32'(acc_at[0]), 32'd0);
        chk("b2b_acc1", 32'(acc_at[1]), 32'd2);
        chk("b2b_acc2", 32'(acc_at[2]), 32'd10);
        chk("b2b_ready", 32'(rdy_got), 32'(rdy_exp));
        chk("b2b_valid", 32'(v_got),   32'(v_exp));
        chk("b2b_fs",    32'(f_got),   32'(f_exp));
        repeat (2) step();

        // Alternating bit_en stretches the word over 16 clocks.
        in_data = 8'hA5; in_valid = 1'b1; bit_en = 1'b0;
        step();
        in_valid = 1'b0; seq = 8'h00; vcnt = 0;
        for (int i = 0; i < 16; i++) begin
            bit_en = (i % 2 == 0);
            step();
            if (ser_valid_v[0]) begin
                seq = {seq[W-2:0], ser_out_v[0]};
                vcnt++;
            end
        end
        chk("alt_seq",  32'(seq),    32'h0000_00A5);
        chk("alt_vcnt", 32'(vcnt),   32'd8);
        chk("alt_busy", 32'(busy_v), 32'd0);
        bit_en = 1'b1;
        step();

        // Asynchronous reset mid-word with a second word buffered.
        in_data = 8'hF0; in_valid = 1'b1;
        step();
        in_data = 8'h55;
        step();
        step();
        in_valid = 1'b0;
        step();
        chk("pre_rst_busy", 32'(busy_v), 32'd3);
        #1 rst = 1'b1;
        #1;
        chk("arst_ser_out",   32'(ser_out_v),   32'd0);
        chk("arst_ser_valid", 32'(ser_valid_v), 32'd0);
        chk("arst_in_ready",  32'(in_ready_v),  32'd3);
        chk("arst_busy",      32'(busy_v),      32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        compare_all();
        rst = 1'b0;
        send_collect(8'h81, sm, sl, vcnt, fsb);
        chk("81_msb_seq", 32'(sm),  32'h0000_0081);
        chk("81_lsb_seq", 32'(sl),  32'h0000_0081);
        chk("81_fs",      32'(fsb), 32'h0000_0001);
        repeat (2) step();

        // A pulse while the buffer is full must not be captured.
        acc0 = n_acc; vcnt = 0;
        in_data = 8'hA5; in_valid = 1'b1;
        step(); vcnt += int'(ser_valid_v[0]);
        in_data = 8'h3C;
        step(); vcnt += int'(ser_valid_v[0]);
        step(); vcnt += int'(ser_valid_v[0]);
        in_valid = 1'b0;
        step(); vcnt += int'(ser_valid_v[0]);
        in_data = 8'hFF; in_valid = 1'b1;
        step(); vcnt += int'(ser_valid_v[0]);
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            vcnt += int'(ser_valid_v[0]);
        end
        chk("drop_accepts", 32'(n_acc - acc0), 32'd2);
        chk("drop_vcnt",    32'(vcnt),         32'd16);
        chk("drop_busy",    32'(busy_v),       32'd0);

        // Randomized traffic against the reference.
        for (int i = 0; i < 600; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = W'($urandom);
            bit_en   = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid = 1'b0; bit_en = 1'b1;
        repeat (20) step();
        chk("rand_drain_busy", 32'(busy_v), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
